// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter and sequencer sharing one multiplier among N_REQ requesters.
// The winner's operands are latched, sent to the multiplier with even-parity bits, and the
// product and error flag are returned to the winner through a one-cycle rsp_valid pulse.
//
// Optional feature: define MULT_ARB_TIMEOUT_EN to abort an operation that has spent TIMEOUT
// cycles in REQ/WAIT without m_result_rdy. The abort returns rsp_timeout = 1 and a zero result.
// When the macro is undefined, rsp_timeout is constant 0 and the arbiter waits indefinitely.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rq_valid/rq_arg_a/rq_arg_b  per-requester request and packed 16-bit operands
//   rq_ready                    one-cycle accept pulse to the granted requester
//   rsp_valid/rsp_result        one-cycle response pulse to the owner, with the 32-bit product
//   rsp_error/rsp_timeout       parity error / timeout abort for that response
//   busy                        high whenever the FSM is not idle
//   m_*                         multiplier req/ack/result_rdy handshake, operands and parity
module mult_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    rq_valid,
   input  logic [N_REQ*16-1:0] rq_arg_a,
   input  logic [N_REQ*16-1:0] rq_arg_b,
   output logic [N_REQ-1:0]    rq_ready,
   output logic [N_REQ-1:0]    rsp_valid,
   output logic [31:0]         rsp_result,
   output logic                rsp_error,
   output logic                rsp_timeout,
   output logic                busy,
   output logic                m_req,
   output logic [15:0]         m_arg_a,
   output logic                m_arg_a_parity,
   output logic [15:0]         m_arg_b,
   output logic                m_arg_b_parity,
   input  logic                m_ack,
   input  logic [31:0]         m_result,
   input  logic                m_result_parity,
   input  logic                m_result_rdy,
   input  logic                m_arg_parity_error
);

   localparam int unsigned IdxW = $clog2(N_REQ);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] ptr_q, ptr_d;
   logic [IdxW-1:0] owner_q, owner_d;
   logic [IdxW-1:0] win, cand;
   logic            win_found;
   logic            capture, tmo;
   logic [15:0]     arg_a_arr [N_REQ];
   logic [15:0]     arg_b_arr [N_REQ];
   logic [15:0]     arg_a_d, arg_b_d;
   logic [31:0]     rsp_result_d;
   logic            rsp_error_d, rsp_timeout_d;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         arg_a_arr[i] = rq_arg_a[16*i +: 16];
         arg_b_arr[i] = rq_arg_b[16*i +: 16];
      end
   end

   // First requesting port at or above ptr_q, wrapping around.
   always_comb begin
      win       = ptr_q;
      win_found = 1'b0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = IdxW'((int'(ptr_q) + k) % N_REQ);
         if (!win_found && rq_valid[cand]) begin
            win       = cand;
            win_found = 1'b1;
         end
      end
   end

`ifdef MULT_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   logic [CntW-1:0] cnt_q;

   // Held at zero in IDLE, so it reads zero in the first REQ cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (state_q == StReq || state_q == StWait) begin
         cnt_q <= cnt_q + 1'b1;
      end else begin
         cnt_q <= '0;
      end
   end
`else
   // Keeps TIMEOUT referenced when the counter is compiled out.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT;
`endif

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      owner_d       = owner_q;
      arg_a_d       = m_arg_a;
      arg_b_d       = m_arg_b;
      rsp_result_d  = rsp_result;
      rsp_error_d   = 1'b0;
      rsp_timeout_d = 1'b0;
      capture       = 1'b0;
      tmo           = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (win_found) begin
               state_d = StReq;
               owner_d = win;
               ptr_d   = IdxW'((int'(win) + 1) % N_REQ);
               arg_a_d = arg_a_arr[win];
               arg_b_d = arg_b_arr[win];
            end
         end
         StReq: begin
            if (m_ack) begin
               state_d = StWait;
               capture = m_result_rdy;
            end
         end
         StWait:  capture = m_result_rdy;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

`ifdef MULT_ARB_TIMEOUT_EN
      // A result strobe on the timeout edge takes priority over the abort.
      if ((state_q == StReq || state_q == StWait) && !capture &&
          cnt_q == CntW'(TIMEOUT - 1)) begin
         tmo = 1'b1;
      end
`endif

      if (capture) begin
         state_d      = StResp;
         rsp_result_d = m_result;
         rsp_error_d  = m_arg_parity_error | (m_result_parity != ^m_result);
      end else if (tmo) begin
         state_d       = StResp;
         rsp_result_d  = '0;
         rsp_timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         ptr_q          <= '0;
         owner_q        <= '0;
         m_req          <= 1'b0;
         rq_ready       <= '0;
         rsp_valid      <= '0;
         rsp_result     <= '0;
         rsp_error      <= 1'b0;
         rsp_timeout    <= 1'b0;
         busy           <= 1'b0;
         m_arg_a        <= '0;
         m_arg_b        <= '0;
         m_arg_a_parity <= 1'b0;
         m_arg_b_parity <= 1'b0;
      end else begin
         state_q        <= state_d;
         ptr_q          <= ptr_d;
         owner_q        <= owner_d;
         m_req          <= (state_d == StReq);
         rq_ready       <= (state_q == StIdle && win_found) ? (N_REQ'(1) << win) : '0;
         rsp_valid      <= (state_d == StResp) ? (N_REQ'(1) << owner_d) : '0;
         rsp_result     <= rsp_result_d;
         rsp_error      <= rsp_error_d;
         rsp_timeout    <= rsp_timeout_d;
         busy           <= (state_d != StIdle);
         m_arg_a        <= arg_a_d;
         m_arg_b        <= arg_b_d;
         m_arg_a_parity <= ^arg_a_d;
         m_arg_b_parity <= ^arg_b_d;
      end
   end

endmodule

// File: tb/tb_mult_arbiter.sv
`timescale 1ns/1ps
module tb_mult_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  rq_valid;
   logic [63:0] rq_arg_a, rq_arg_b;
   logic [3:0]  rq_ready, rsp_valid;
   logic [31:0] rsp_result;
   logic        rsp_error, rsp_timeout, busy, m_req;
   logic [15:0] m_arg_a, m_arg_b;
   logic        m_arg_a_parity, m_arg_b_parity;
   logic        m_ack, m_result_parity, m_result_rdy, m_arg_parity_error;
   logic [31:0] m_result;

   logic [15:0] op_a [4];
   logic [15:0] op_b [4];
   assign rq_arg_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
   assign rq_arg_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

   always #5 clk = ~clk;

   mult_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .rq_valid(rq_valid), .rq_arg_a(rq_arg_a), .rq_arg_b(rq_arg_b),
      .rq_ready(rq_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
      .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .busy(busy),
      .m_req(m_req), .m_arg_a(m_arg_a), .m_arg_a_parity(m_arg_a_parity),
      .m_arg_b(m_arg_b), .m_arg_b_parity(m_arg_b_parity),
      .m_ack(m_ack), .m_result(m_result), .m_result_parity(m_result_parity),
      .m_result_rdy(m_result_rdy), .m_arg_parity_error(m_arg_parity_error)
   );

   typedef struct packed {
      logic [3:0] vec; logic [15:0] a; logic pa; logic [15:0] b; logic pb;
   } grant_t;
   typedef struct packed {
      logic [3:0] vec; logic [31:0] res; logic err; logic tmo;
   } rsp_t;

   grant_t gq [$];
   rsp_t   rq [$];
   int     n_vec = 0;
   int     n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endtask

   task automatic push_grant(input logic [3:0] vec, input logic [15:0] a, input logic pa,
                             input logic [15:0] b, input logic pb);
      grant_t g;
      g.vec = vec; g.a = a; g.pa = pa; g.b = b; g.pb = pb;
      gq.push_back(g);
   endtask

   task automatic push_rsp(input logic [3:0] vec, input logic [31:0] res, input logic err,
                           input logic tmo);
      rsp_t r;
      r.vec = vec; r.res = res; r.err = err; r.tmo = tmo;
      rq.push_back(r);
   endtask

   // Multiplier model: acks a request, then strobes the result mdl_delay cycles later.
   int   mdl_delay   = 0;
   bit   mdl_never   = 0;
   bit   mdl_arg_err = 0;
   bit   mdl_bad_par = 0;
   bit   pending     = 0;
   int   dly         = 0;

   task automatic drive_result();
      logic signed [31:0] p;
      p = 32'($signed(m_arg_a)) * 32'($signed(m_arg_b));
      m_result_rdy       = 1'b1;
      m_arg_parity_error = mdl_arg_err;
      if (mdl_bad_par) begin
         m_result        = 32'h0000_0001;
         m_result_parity = 1'b0;
      end else begin
         m_result        = p;
         m_result_parity = ^p;
      end
   endtask

   initial begin
      m_ack = 0; m_result_rdy = 0; m_arg_parity_error = 0; m_result = '0; m_result_parity = 0;
      forever begin
         @(negedge clk);
         m_ack = 0; m_result_rdy = 0; m_arg_parity_error = 0; m_result = '0; m_result_parity = 0;
         if (!rst_n) begin
            pending = 0;
         end else if (pending) begin
            if (dly == 0) begin
               drive_result();
               pending = 0;
            end else begin
               dly--;
            end
         end else if (m_req) begin
            m_ack = 1'b1;
            if (!mdl_never) begin
               if (mdl_delay == 0) drive_result();
               else begin pending = 1; dly = mdl_delay - 1; end
            end
         end
      end
   end

   // Scoreboard monitors.
   logic [3:0] prev_ready = '0;
   logic [3:0] prev_rspv  = '0;
   grant_t     mg;
   rsp_t       mr;

   always @(negedge clk) begin
      if (rq_ready != 0) begin
         check("rq_ready single-cycle", prev_ready, 0);
         if (gq.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected grant: rq_ready=%b, required none", rq_ready);
         end else begin
            mg = gq.pop_front();
            check("grant vector", rq_ready, mg.vec);
            check("m_req at grant", m_req, 1);
            check("m_arg_a", m_arg_a, mg.a);
            check("m_arg_a_parity", m_arg_a_parity, mg.pa);
            check("m_arg_b", m_arg_b, mg.b);
            check("m_arg_b_parity", m_arg_b_parity, mg.pb);
         end
      end
      prev_ready = rq_ready;
   end

   always @(negedge clk) begin
      if (rsp_valid != 0) begin
         check("rsp_valid single-cycle", prev_rspv, 0);
         if (rq.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected response: rsp_valid=%b, required none", rsp_valid);
         end else begin
            mr = rq.pop_front();
            check("rsp_valid vector", rsp_valid, mr.vec);
            check("rsp_result", rsp_result, mr.res);
            check("rsp_error", rsp_error, mr.err);
            check("rsp_timeout", rsp_timeout, mr.tmo);
         end
      end
      prev_rspv = rsp_valid;
   end

   task automatic wait_ready(output logic [3:0] got);
      got = '0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (rq_ready != 0) begin
            got = rq_ready;
            return;
         end
      end
      n_vec++; n_bad++;
      $display("FAIL rq_ready wait: got no pulse in 300 cycles, required a grant");
   endtask

   // Each port in mask issues nper operations; its valid drops after its last grant.
   task automatic run_ops(input logic [3:0] mask, input int nper);
      int         left [4];
      logic [3:0] got;
      for (int i = 0; i < 4; i++) left[i] = mask[i] ? nper : 0;
      rq_valid = mask;
      while (rq_valid != 0) begin
         wait_ready(got);
         if (got == 0) begin
            rq_valid = '0;
            break;
         end
         for (int i = 0; i < 4; i++) begin
            if (got[i]) begin
               left[i]--;
               if (left[i] <= 0) rq_valid[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 400; i++) begin
         if (rq.size() == 0 && gq.size() == 0) break;
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic set_rr_ops();
      op_a[0] = 16'h0002; op_b[0] = 16'h0003;
      op_a[1] = 16'hFFFF; op_b[1] = 16'h0002;
      op_a[2] = 16'h0100; op_b[2] = 16'h0010;
      op_a[3] = 16'h0007; op_b[3] = 16'hFFFD;
   endtask

   task automatic push_rr(input int port);
      case (port)
         0: begin push_grant(4'b0001, 16'h0002, 1, 16'h0003, 0); push_rsp(4'b0001, 32'h0000_0006, 0, 0); end
         1: begin push_grant(4'b0010, 16'hFFFF, 0, 16'h0002, 1); push_rsp(4'b0010, 32'hFFFF_FFFE, 0, 0); end
         2: begin push_grant(4'b0100, 16'h0100, 1, 16'h0010, 1); push_rsp(4'b0100, 32'h0000_1000, 0, 0); end
         default: begin push_grant(4'b1000, 16'h0007, 1, 16'hFFFD, 1); push_rsp(4'b1000, 32'hFFFF_FFEB, 0, 0); end
      endcase
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   logic [3:0] got;

   initial begin
      rq_valid = '0;
      for (int i = 0; i < 4; i++) begin op_a[i] = '0; op_b[i] = '0; end
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("reset rq_ready", rq_ready, 0);
      check("reset rsp_valid", rsp_valid, 0);
      check("reset busy", busy, 0);
      check("reset m_req", m_req, 0);
      check("reset m_arg_a", m_arg_a, 0);
      check("reset m_arg_b", m_arg_b, 0);
      check("reset parities", {m_arg_a_parity, m_arg_b_parity}, 0);
      check("reset rsp_result", rsp_result, 0);
      check("reset rsp_error/timeout", {rsp_error, rsp_timeout}, 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);

      // Single operation on port 2, minimum latency.
      op_a[2] = 16'h0003; op_b[2] = 16'hFFFB;
      mdl_delay = 0;
      push_grant(4'b0100, 16'h0003, 0, 16'hFFFB, 1);
      push_rsp(4'b0100, 32'hFFFF_FFF1, 0, 0);
      rq_valid = 4'b0100;
      wait_ready(got);
      rq_valid = '0;
      @(negedge clk);
      check("min latency rsp_valid", rsp_valid, 4'b0100);
      @(negedge clk);
      check("busy after response", busy, 0);
      drain();

      // Reset puts the pointer back at 0, then round robin with all ports requesting.
      #1 rst_n = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      set_rr_ops();
      mdl_delay = 1;
      for (int n = 0; n < 8; n++) push_rr(n % 4);
      run_ops(4'hF, 2);
      drain();

      // Argument parity error on port 1, then a clean operation on port 3.
      op_a[1] = 16'h1234; op_b[1] = 16'h0002;
      mdl_delay = 2; mdl_arg_err = 1;
      push_grant(4'b0010, 16'h1234, 1, 16'h0002, 1);
      push_rsp(4'b0010, 32'h0000_2468, 1, 0);
      run_ops(4'b0010, 1);
      drain();
      mdl_arg_err = 0;
      op_a[3] = 16'h8000; op_b[3] = 16'h8000;
      push_grant(4'b1000, 16'h8000, 1, 16'h8000, 1);
      push_rsp(4'b1000, 32'h4000_0000, 0, 0);
      run_ops(4'b1000, 1);
      drain();

      // Result parity mismatch on port 0.
      mdl_bad_par = 1;
      op_a[0] = 16'h0005; op_b[0] = 16'h0006;
      push_grant(4'b0001, 16'h0005, 0, 16'h0006, 0);
      push_rsp(4'b0001, 32'h0000_0001, 1, 0);
      run_ops(4'b0001, 1);
      drain();
      mdl_bad_par = 0;

`ifdef MULT_ARB_TIMEOUT_EN
      // Multiplier acks but never returns a result.
      mdl_never = 1;
      op_a[2] = 16'h0003; op_b[2] = 16'hFFFB;
      push_grant(4'b0100, 16'h0003, 0, 16'hFFFB, 1);
      push_rsp(4'b0100, 32'h0000_0000, 0, 1);
      rq_valid = 4'b0100;
      wait_ready(got);
      rq_valid = '0;
      begin
         int k;
         for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rsp_valid != 0) break;
         end
         check("timeout latency", k, 16);
      end
      @(negedge clk);
      check("busy after timeout", busy, 0);
      mdl_never = 0;
      drain();
`endif

      // Reset while waiting for the result; the in-flight operation gets no response.
      set_rr_ops();
      mdl_delay = 6;
`ifdef MULT_ARB_TIMEOUT_EN
      push_grant(4'b1000, 16'h0007, 1, 16'hFFFD, 1);
`else
      push_grant(4'b0010, 16'hFFFF, 0, 16'h0002, 1);
`endif
      rq_valid = 4'hF;
      wait_ready(got);
      @(negedge clk);
      check("in WAIT m_req", m_req, 0);
      check("in WAIT busy", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      check("reset in WAIT m_req", m_req, 0);
      check("reset in WAIT busy", busy, 0);
      check("reset in WAIT rsp_valid", rsp_valid, 0);
      repeat (2) @(negedge clk);
      mdl_delay = 0;
      for (int n = 0; n < 4; n++) push_rr(n);
      #1 rst_n = 1'b1;
      run_ops(4'hF, 1);
      drain();

      check("grant queue empty", gq.size(), 0);
      check("response queue empty", rq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
